// File: rtl/dispatch_ram.sv
// dispatch_ram: 2048-entry dispatch memory with a registered read port and an IDLE/WSETUP/WPULSE write sequencer.
// Define DISPATCH_PARITY_EN to store an odd-parity bit per word and raise a sticky dparerr on read mismatch.
module dispatch_ram (
    input  logic        clk,
    input  logic        reset,
    input  logic        state_fetch,
    input  logic        irdisp,
    input  logic        dispwr,
    input  logic [6:0]  dmask,
    input  logic        dmapbenb,
    input  logic [48:0] ir,
    input  logic [6:0]  r,
    input  logic        map_bit,
    input  logic [16:0] a,
    output logic [13:0] dpc,
    output logic        dn,
    output logic        dp,
    output logic        dr,
    output logic        dbusy,
    output logic        dparerr
);

`ifdef DISPATCH_PARITY_EN
    localparam int unsigned WIDTH = 18;
`else
    localparam int unsigned WIDTH = 17;
`endif

    typedef enum logic [1:0] {IDLE, WSETUP, WPULSE} wstate_t;

    wstate_t          state, state_nxt;
    logic [WIDTH-1:0] mem [0:2047];
    logic [10:0]      dadr;
    logic [10:0]      wadr;
    logic [16:0]      wdata;
    logic [WIDTH-1:0] wword;
    logic [WIDTH-1:0] rword;
    logic             rd_go;
    logic             wr_go;
    logic             unused_ir;

    assign unused_ir = ^{ir[48:23], ir[11:0]};

    always_comb begin
        dadr    = {ir[22:19], ir[18:12] | (r & dmask)};
        dadr[0] = dadr[0] | (dmapbenb & map_bit);
    end

    assign dbusy = (state != IDLE);
    assign wr_go = state_fetch & dispwr & (state == IDLE);
    // A qualifying write request always suppresses the read in the same cycle.
    assign rd_go = state_fetch & irdisp & ~dispwr & ~dbusy;
    assign rword = mem[dadr];

`ifdef DISPATCH_PARITY_EN
    assign wword = {~^wdata, wdata};
`else
    assign wword = wdata;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (wr_go) state_nxt = WSETUP;
            WSETUP:  state_nxt = WPULSE;
            WPULSE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (wr_go) begin
            wadr  <= dadr;
            wdata <= a;
        end
    end

    // Storage is never cleared; a reset coinciding with WPULSE drops the commit.
    always_ff @(posedge clk) begin
        if (reset && state == WPULSE) mem[wadr] <= wword;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            {dr, dp, dn, dpc} <= '0;
        end else if (rd_go) begin
            {dr, dp, dn, dpc} <= rword[16:0];
        end
    end

`ifdef DISPATCH_PARITY_EN
    always_ff @(posedge clk) begin
        if (!reset)                 dparerr <= 1'b0;
        else if (rd_go && !(^rword)) dparerr <= 1'b1;
    end
`else
    assign dparerr = 1'b0;
`endif

endmodule

// File: tb/tb_dispatch_ram.sv
// Randomized self-checking bench for dispatch_ram against a countdown-based behavioural model.
module tb_dispatch_ram;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        state_fetch = 1'b0;
    logic        irdisp = 1'b0;
    logic        dispwr = 1'b0;
    logic [6:0]  dmask = '0;
    logic        dmapbenb = 1'b0;
    logic [48:0] ir = '0;
    logic [6:0]  r = '0;
    logic        map_bit = 1'b0;
    logic [16:0] a = '0;
    logic [13:0] dpc;
    logic        dn, dp, dr, dbusy, dparerr;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    dispatch_ram dut (
        .clk(clk), .reset(reset), .state_fetch(state_fetch), .irdisp(irdisp),
        .dispwr(dispwr), .dmask(dmask), .dmapbenb(dmapbenb), .ir(ir), .r(r),
        .map_bit(map_bit), .a(a), .dpc(dpc), .dn(dn), .dp(dp), .dr(dr),
        .dbusy(dbusy), .dparerr(dparerr)
    );

    always #5 clk = ~clk;

    // Model: memory image, last read word, remaining busy cycles, pending write, sticky error.
    logic [16:0] m_mem [0:2047];
    bit          m_bad [0:2047];
    logic [16:0] m_out = '0;
    int          m_busy = 0;
    logic        m_perr = 1'b0;
    logic [10:0] m_padr = '0;
    logic [16:0] m_pdat = '0;

    function automatic logic [10:0] addr_of();
        int lo;
        lo = int'(ir[18:12]) | (int'(r) & int'(dmask));
        if (dmapbenb && map_bit) lo = lo | 1;
        return 11'(int'(ir[22:19]) * 128 + lo);
    endfunction

    always @(posedge clk) begin : model
        logic [10:0] ad;
        ad = addr_of();
        if (!reset) begin
            m_out  = '0;
            m_busy = 0;
            m_perr = 1'b0;
        end else if (m_busy != 0) begin
            m_busy = m_busy - 1;
            if (m_busy == 0) begin
                m_mem[m_padr] = m_pdat;
                m_bad[m_padr] = 1'b0;
            end
        end else if (state_fetch && dispwr) begin
            m_padr = ad;
            m_pdat = a;
            m_busy = 2;
        end else if (state_fetch && irdisp) begin
            m_out = m_mem[ad];
            if (m_bad[ad]) m_perr = 1'b1;
        end
    end

    task automatic check(input string nm, input logic [16:0] act, input logic [16:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_out", {dr, dp, dn, dpc}, m_out);
            check("model_dbusy", 17'(dbusy), 17'(m_busy != 0));
            check("model_dparerr", 17'(dparerr), 17'(m_perr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_addr(input logic [10:0] ad);
        ir[22:12] = ad;
        dmask     = '0;
        dmapbenb  = 1'b0;
    endtask

    task automatic idle_inputs();
        state_fetch = 1'b0;
        irdisp      = 1'b0;
        dispwr      = 1'b0;
    endtask

    task automatic wr(input logic [10:0] ad, input logic [16:0] d);
        set_addr(ad);
        a           = d;
        state_fetch = 1'b1;
        irdisp      = 1'b1;
        dispwr      = 1'b1;
        tick();
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic rd(input logic [10:0] ad);
        set_addr(ad);
        state_fetch = 1'b1;
        irdisp      = 1'b1;
        dispwr      = 1'b0;
        tick();
        idle_inputs();
    endtask

    logic [63:0] rnd64;

    initial begin
        tick();
        tick();
        chk_en = 1'b1;
        check("reset_out", {dr, dp, dn, dpc}, 17'h0);
        check("reset_dbusy", 17'(dbusy), 17'h0);
        check("reset_dparerr", 17'(dparerr), 17'h0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 2048; i++) wr(11'(i), 17'($urandom));

        // Write, then read back the same location; dbusy spans exactly two cycles.
        set_addr(11'h155);
        a = 17'h1_2345;
        state_fetch = 1'b1; irdisp = 1'b1; dispwr = 1'b1;
        tick();
        idle_inputs();
        check("wr_busy_c1", 17'(dbusy), 17'h1);
        tick();
        check("wr_busy_c2", 17'(dbusy), 17'h1);
        tick();
        check("wr_busy_c3", 17'(dbusy), 17'h0);
        rd(11'h155);
        check("rd_word", {dr, dp, dn, dpc}, 17'h1_2345);
        check("rd_dpc", 17'(dpc), 17'h2345);
        check("rd_flags", {14'h0, dr, dp, dn}, 17'h4);

        // Address formation with mask and map bit: 400 | (05 & 0F) | 1 = 405.
        ir[22:12] = 11'h400; dmask = 7'h0F; r = 7'h05; dmapbenb = 1'b1; map_bit = 1'b1;
        a = 17'h0_5A5A;
        state_fetch = 1'b1; irdisp = 1'b1; dispwr = 1'b1;
        tick();
        idle_inputs();
        tick();
        tick();
        rd(11'h405);
        check("addr_form", {dr, dp, dn, dpc}, 17'h0_5A5A);

        // Second request during busy is dropped.
        wr(11'h0CD, 17'h0_AAAA);
        wr(11'h0EF, 17'h0_AAAA);
        set_addr(11'h0CD);
        a = 17'h1_5555;
        state_fetch = 1'b1; irdisp = 1'b1; dispwr = 1'b1;
        tick();
        set_addr(11'h0EF);
        a = 17'h1_FFFF;
        tick();
        tick();
        idle_inputs();
        rd(11'h0EF);
        check("busy_drop_2nd", {dr, dp, dn, dpc}, 17'h0_AAAA);
        rd(11'h0CD);
        check("busy_keep_1st", {dr, dp, dn, dpc}, 17'h1_5555);

        // Reset in WSETUP abandons the write.
        wr(11'h010, 17'h0_3210);
        rd(11'h0CD);
        set_addr(11'h010);
        a = 17'h1_ABCD;
        state_fetch = 1'b1; irdisp = 1'b1; dispwr = 1'b1;
        tick();
        idle_inputs();
        reset = 1'b0;
        tick();
        check("rst_setup_out", {dr, dp, dn, dpc}, 17'h0);
        check("rst_setup_busy", 17'(dbusy), 17'h0);
        reset = 1'b1;
        rd(11'h010);
        check("rst_setup_keep", {dr, dp, dn, dpc}, 17'h0_3210);

        // Reset coinciding with WPULSE suppresses the commit.
        set_addr(11'h010);
        a = 17'h1_ABCD;
        state_fetch = 1'b1; irdisp = 1'b1; dispwr = 1'b1;
        tick();
        idle_inputs();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        rd(11'h010);
        check("rst_pulse_keep", {dr, dp, dn, dpc}, 17'h0_3210);

        // Read and write in the same cycle: write wins, outputs hold.
        rd(11'h155);
        set_addr(11'h010);
        a = 17'h0_0777;
        state_fetch = 1'b1; irdisp = 1'b1; dispwr = 1'b1;
        tick();
        idle_inputs();
        check("wr_prio_hold", {dr, dp, dn, dpc}, 17'h1_2345);
        check("wr_prio_busy", 17'(dbusy), 17'h1);
        tick();
        tick();
        rd(11'h010);
        check("wr_prio_land", {dr, dp, dn, dpc}, 17'h0_0777);

`ifdef DISPATCH_PARITY_EN
        dut.mem[11'h155][0] = ~dut.mem[11'h155][0];
        m_mem[11'h155][0] = ~m_mem[11'h155][0];
        m_bad[11'h155] = 1'b1;
        rd(11'h155);
        check("par_err_set", 17'(dparerr), 17'h1);
        tick();
        tick();
        rd(11'h010);
        check("par_err_sticky", 17'(dparerr), 17'h1);
        reset = 1'b0;
        tick();
        check("par_err_clear", 17'(dparerr), 17'h0);
        reset = 1'b1;
        wr(11'h155, 17'h1_2345);
`else
        rd(11'h155);
        check("par_err_off", 17'(dparerr), 17'h0);
`endif

        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 59) != 0);
            state_fetch = 1'($urandom);
            irdisp      = 1'($urandom);
            dispwr      = irdisp & 1'($urandom);
            rnd64       = {$urandom, $urandom};
            ir          = rnd64[48:0];
            ir[22:12]   = 11'h100 + 11'($urandom_range(0, 15));
            dmask       = 7'($urandom);
            r           = 7'($urandom);
            dmapbenb    = 1'($urandom);
            map_bit     = 1'($urandom);
            a           = 17'($urandom);
            tick();
        end

        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
